// File: rtl/conv_mem_responder.sv
// Two-bank memory responder for a convolution engine: CPU-style read/write while
// the engine runs, then a ready/valid dump of L0 followed by L1 once busy falls.
module conv_mem_responder #(
    parameter int DW       = 20,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [2:0]    dump_sel,
    output logic [11:0]   dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          done,
    output logic          err
);

    localparam int          L0_AW    = $clog2(L0_DEPTH);
    localparam int          L1_AW    = $clog2(L1_DEPTH);
    localparam logic [2:0]  SEL_L0   = 3'b001;
    localparam logic [2:0]  SEL_L1   = 3'b011;
    localparam logic [12:0] L0_LIMIT = 13'(L0_DEPTH);
    localparam logic [12:0] L1_LIMIT = 13'(L1_DEPTH);
    localparam logic [11:0] L0_LAST  = 12'(L0_DEPTH - 1);
    localparam logic [11:0] L1_LAST  = 12'(L1_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, RUN, DUMP_L0, DUMP_L1, FIN} state_t;

    state_t        state, state_next;
    logic          busy_q;
    logic [DW-1:0] l0_mem [L0_DEPTH];
    logic [DW-1:0] l1_mem [L1_DEPTH];

    logic          dumping, dump_xfer, dump_load;
    logic          wr_l0, wr_l1, rd_l0, rd_l1, bad_access;
    logic [11:0]   fetch_addr;
    logic          fetch_l1, fetch_done;

    assign dumping   = (state == DUMP_L0) || (state == DUMP_L1);
    assign dump_xfer = dump_valid && dump_ready;
    assign dump_load = dumping && !fetch_done && (!dump_valid || dump_ready);

    // Host accesses are only honoured outside a dump and inside the bank's range.
    assign wr_l0 = cwr && !dumping && (csel == SEL_L0) && ({1'b0, caddr_wr} < L0_LIMIT);
    assign wr_l1 = cwr && !dumping && (csel == SEL_L1) && ({1'b0, caddr_wr} < L1_LIMIT);
    assign rd_l0 = crd && !dumping && (csel == SEL_L0) && ({1'b0, caddr_rd} < L0_LIMIT);
    assign rd_l1 = crd && !dumping && (csel == SEL_L1) && ({1'b0, caddr_rd} < L1_LIMIT);

    assign bad_access = (dumping && (cwr || crd))
                      || (cwr && !dumping && !(wr_l0 || wr_l1))
                      || (crd && !dumping && !(rd_l0 || rd_l1));

    always_ff @(posedge clk) begin
        if (wr_l0) l0_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        if (wr_l1) l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end

    // Non-blocking memory update makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdata_rd <= '0;
        end else if (crd && !dumping) begin
            if (rd_l0)      cdata_rd <= l0_mem[caddr_rd[L0_AW-1:0]];
            else if (rd_l1) cdata_rd <= l1_mem[caddr_rd[L1_AW-1:0]];
            else            cdata_rd <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)           err <= 1'b0;
        else if (bad_access) err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= busy;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:    if (busy) state_next = RUN;
            RUN:     if (busy_q && !busy) state_next = DUMP_L0;
            DUMP_L0: if (dump_xfer && dump_sel == SEL_L0 && dump_addr == L0_LAST) state_next = DUMP_L1;
            DUMP_L1: if (dump_xfer && dump_sel == SEL_L1 && dump_addr == L1_LAST) state_next = FIN;
            FIN: begin
                done = 1'b1;
                if (busy) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // The fetch pointer runs one word ahead across both banks so the L0->L1 seam has no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr <= '0;
            fetch_l1   <= 1'b0;
            fetch_done <= 1'b0;
            dump_valid <= 1'b0;
            dump_sel   <= '0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else if (!dumping) begin
            fetch_addr <= '0;
            fetch_l1   <= 1'b0;
            fetch_done <= 1'b0;
            dump_valid <= 1'b0;
        end else if (dump_load) begin
            dump_valid <= 1'b1;
            dump_addr  <= fetch_addr;
            if (fetch_l1) begin
                dump_sel  <= SEL_L1;
                dump_data <= l1_mem[fetch_addr[L1_AW-1:0]];
                if (fetch_addr == L1_LAST) fetch_done <= 1'b1;
                else                       fetch_addr <= fetch_addr + 12'd1;
            end else begin
                dump_sel  <= SEL_L0;
                dump_data <= l0_mem[fetch_addr[L0_AW-1:0]];
                if (fetch_addr == L0_LAST) begin
                    fetch_l1   <= 1'b1;
                    fetch_addr <= '0;
                end else begin
                    fetch_addr <= fetch_addr + 12'd1;
                end
            end
        end else if (dump_xfer) begin
            dump_valid <= 1'b0;
        end
    end

endmodule
